// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code step monitor.
package gray_pkg;

    // Tracking FSM: IDLE has no reference sample, TRACK compares against one.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

    // Default width of the saturating step-error counter.
    localparam int ERR_W = 8;

    // Default Gray/binary width.
    localparam int WIDTH_DEFAULT = 3;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder, exact inverse of the upstream encoder.
module gray_to_bin #(
    parameter int width = 3
) (
    input  logic [width-1:0] grey_i,
    output logic [width-1:0] bin_o
);

    // bin[i] = bin[i+1] ^ grey[i] unrolls to the XOR of all Gray bits from
    // the MSB down to i.  Using the reduction form avoids a vector that
    // reads back its own bits.
    for (genvar i = 0; i < width; i++) begin : g_bit
        assign bin_o[i] = ^grey_i[width-1:i];
    end

endmodule

// File: rtl/gray_monitor.sv
// Gray-code sample monitor: decodes each accepted sample, classifies the step
// from the previous sample (hold / legal +-1 / illegal jump), tracks the
// direction of the last legal step and counts illegal jumps with saturation.
module gray_monitor #(
    parameter int width = 3,
    parameter int ERR_W = gray_pkg::ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             grey_valid,
    input  logic [width-1:0] grey,
    output logic             bin_valid,
    output logic [width-1:0] bin_out,
    output logic             dir_up,
    output logic             hold,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    import gray_pkg::*;

    // Wide enough to hold a Hamming distance of up to 'width' bits.
    localparam int CNT_W = $clog2(width + 1);

    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] BIN_ONE  = {{(width-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DIST_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DIST_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Full-width population count; the accumulator is sized for 'width' ones.
    function automatic logic [CNT_W-1:0] popcount(input logic [width-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < width; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    state_e             state_q,    state_d;
    logic [width-1:0]   ref_q,      ref_d;
    logic [width-1:0]   bin_q,      bin_d;
    logic               valid_q,    valid_d;
    logic               dir_up_q,   dir_up_d;
    logic               hold_q,     hold_d;
    logic               err_q,      err_d;
    logic [ERR_W-1:0]   cnt_q,      cnt_d;
    logic               locked_q,   locked_d;

    logic [width-1:0]   bin_s;
    logic [CNT_W-1:0]   dist_s;

    gray_to_bin #(
        .width (width)
    ) u_gray_to_bin (
        .grey_i (grey),
        .bin_o  (bin_s)
    );

    assign dist_s = popcount(grey ^ ref_q);

    // Next-state logic: clear wins over a sample; a sample in IDLE locks,
    // a sample in TRACK is classified by its distance from the reference.
    // bin_q always holds the decode of ref_q, so it serves as the reference bin.
    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        bin_d    = bin_q;
        valid_d  = 1'b0;
        dir_up_d = dir_up_q;
        hold_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = {ERR_W{1'b0}};
        end else if (grey_valid) begin
            valid_d = 1'b1;
            ref_d   = grey;
            bin_d   = bin_s;
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (dist_s == DIST_ZERO) begin
                        hold_d = 1'b1;
                    end else if (dist_s == DIST_ONE) begin
                        // Wrap from all-ones to zero falls out of the modular add.
                        dir_up_d = (bin_s == (bin_q + BIN_ONE));
                    end else begin
                        err_d = 1'b1;
                        if (cnt_q != ERR_MAX) begin
                            cnt_d = cnt_q + ERR_ONE;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == TRACK);
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ref_q    <= {width{1'b0}};
            bin_q    <= {width{1'b0}};
            valid_q  <= 1'b0;
            dir_up_q <= 1'b1;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= {ERR_W{1'b0}};
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            dir_up_q <= dir_up_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign bin_valid = valid_q;
    assign bin_out   = bin_q;
    assign dir_up    = dir_up_q;
    assign hold      = hold_q;
    assign step_err  = err_q;
    assign err_count = cnt_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Directed bench for gray_monitor (width=3): one DUT with the default error
// counter and one with a 2-bit counter for the saturation scenario.
module tb_gray_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, gv;
    logic [2:0] g;
    logic       bv, du, hd, se, lk;
    logic [2:0] bo;
    logic [7:0] ec;

    logic       clr2, gv2;
    logic [2:0] g2;
    logic       bv2, du2, hd2, se2, lk2;
    logic [2:0] bo2;
    logic [1:0] ec2;

    int checks   = 0;
    int failures = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    gray_monitor #(.width(3), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .grey_valid(gv), .grey(g),
        .bin_valid(bv), .bin_out(bo), .dir_up(du), .hold(hd),
        .step_err(se), .err_count(ec), .locked(lk)
    );

    gray_monitor #(.width(3), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .grey_valid(gv2), .grey(g2),
        .bin_valid(bv2), .bin_out(bo2), .dir_up(du2), .hold(hd2),
        .step_err(se2), .err_count(ec2), .locked(lk2)
    );

    // One clock on dut: drive at negedge, sample #1 after the rising edge.
    task automatic drive(input logic c, input logic v, input logic [2:0] gg);
        @(negedge clk);
        clr = c; gv = v; g = gg;
        @(posedge clk);
        #1;
        clr = 1'b0; gv = 1'b0;
    endtask

    // Same for dut2.
    task automatic drive2(input logic c, input logic v, input logic [2:0] gg);
        @(negedge clk);
        clr2 = c; gv2 = v; g2 = gg;
        @(posedge clk);
        #1;
        clr2 = 1'b0; gv2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; gv = 1'b0; g = 3'd0;
        clr2 = 1'b0; gv2 = 1'b0; g2 = 3'd0;
        #12;
        checks++; if (bv !== 1'b0) begin failures++; $display("FAIL reset_bin_valid act=%b exp=0", bv); end
        checks++; if (bo !== 3'd0) begin failures++; $display("FAIL reset_bin_out act=%0d exp=0", bo); end
        checks++; if (du !== 1'b1) begin failures++; $display("FAIL reset_dir_up act=%b exp=1", du); end
        checks++; if (hd !== 1'b0 || se !== 1'b0) begin failures++; $display("FAIL reset_hold_err act=%b%b exp=00", hd, se); end
        checks++; if (ec !== 8'd0) begin failures++; $display("FAIL reset_err_count act=%0d exp=0", ec); end
        checks++; if (lk !== 1'b0 || lk2 !== 1'b0) begin failures++; $display("FAIL reset_locked act=%b%b exp=00", lk, lk2); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'b000);
        checks++; if (lk !== 1'b0 || bv !== 1'b0) begin failures++; $display("FAIL idle_after_reset act=%b%b exp=00", lk, bv); end
    endtask

    task automatic test_increment();
        logic [2:0] seq [9];
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        for (int i = 0; i < 9; i++) begin
            logic [2:0] exp_b;
            exp_b = 3'(i % 8);
            drive(1'b0, 1'b1, seq[i]);
            checks++;
            if (bv !== 1'b1 || bo !== exp_b || du !== 1'b1 || se !== 1'b0 || hd !== 1'b0 || lk !== 1'b1) begin
                failures++;
                $display("FAIL inc_step%0d act v=%b b=%0d up=%b err=%b hold=%b lk=%b exp v=1 b=%0d up=1 err=0 hold=0 lk=1",
                         i, bv, bo, du, se, hd, lk, exp_b);
            end
        end
        checks++; if (ec !== 8'd0) begin failures++; $display("FAIL inc_err_count act=%0d exp=0", ec); end
        drive(1'b0, 1'b0, 3'b111);
        checks++; if (bv !== 1'b0 || bo !== 3'd0 || hd !== 1'b0 || se !== 1'b0) begin
            failures++; $display("FAIL inc_gap act v=%b b=%0d h=%b e=%b exp v=0 b=0 h=0 e=0", bv, bo, hd, se);
        end
    endtask

    task automatic test_decrement();
        drive(1'b1, 1'b0, 3'b000);
        checks++; if (lk !== 1'b0 || bv !== 1'b0) begin failures++; $display("FAIL dec_clr act=%b%b exp=00", lk, bv); end
        drive(1'b0, 1'b1, 3'b000);
        checks++; if (bo !== 3'd0 || du !== 1'b1 || lk !== 1'b1) begin failures++; $display("FAIL dec_first act b=%0d up=%b lk=%b exp b=0 up=1 lk=1", bo, du, lk); end
        drive(1'b0, 1'b1, 3'b100);
        checks++; if (bo !== 3'd7 || du !== 1'b0 || se !== 1'b0) begin failures++; $display("FAIL dec_second act b=%0d up=%b e=%b exp b=7 up=0 e=0", bo, du, se); end
        drive(1'b0, 1'b1, 3'b101);
        checks++; if (bo !== 3'd6 || du !== 1'b0) begin failures++; $display("FAIL dec_third act b=%0d up=%b exp b=6 up=0", bo, du); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 3'b000);
        drive(1'b0, 1'b1, 3'b011);
        checks++; if (se !== 1'b1 || bo !== 3'd2 || ec !== 8'd1 || du !== 1'b0 || hd !== 1'b0) begin
            failures++; $display("FAIL jump_000_011 act e=%b b=%0d cnt=%0d up=%b h=%b exp e=1 b=2 cnt=1 up=0 h=0", se, bo, ec, du, hd);
        end
        drive(1'b0, 1'b1, 3'b011);
        checks++; if (hd !== 1'b1 || se !== 1'b0 || ec !== 8'd1 || bo !== 3'd2) begin
            failures++; $display("FAIL repeat_hold act h=%b e=%b cnt=%0d b=%0d exp h=1 e=0 cnt=1 b=2", hd, se, ec, bo);
        end
        drive(1'b0, 1'b0, 3'b011);
        checks++; if (bv !== 1'b0 || hd !== 1'b0 || se !== 1'b0 || bo !== 3'd2) begin
            failures++; $display("FAIL invalid_quiet act v=%b h=%b e=%b b=%0d exp v=0 h=0 e=0 b=2", bv, hd, se, bo);
        end
        drive(1'b0, 1'b1, 3'b100);
        checks++; if (se !== 1'b1 || bo !== 3'd7 || ec !== 8'd2) begin
            failures++; $display("FAIL jump_dist3 act e=%b b=%0d cnt=%0d exp e=1 b=7 cnt=2", se, bo, ec);
        end
        drive(1'b0, 1'b1, 3'b100);
        checks++; if (se !== 1'b0 || hd !== 1'b1) begin failures++; $display("FAIL err_pulse_end act e=%b h=%b exp e=0 h=1", se, hd); end
    endtask

    task automatic test_saturation();
        logic [2:0] jumps [5];
        logic [1:0] exp_c [5];
        jumps = '{3'b011, 3'b000, 3'b011, 3'b000, 3'b011};
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        drive2(1'b0, 1'b1, 3'b000);
        for (int i = 0; i < 5; i++) begin
            drive2(1'b0, 1'b1, jumps[i]);
            checks++;
            if (se2 !== 1'b1 || ec2 !== exp_c[i]) begin
                failures++; $display("FAIL sat_jump%0d act e=%b cnt=%0d exp e=1 cnt=%0d", i, se2, ec2, exp_c[i]);
            end
        end
        drive2(1'b0, 1'b1, 3'b011);
        checks++; if (ec2 !== 2'd3 || hd2 !== 1'b1 || se2 !== 1'b0) begin
            failures++; $display("FAIL sat_hold act cnt=%0d h=%b e=%b exp cnt=3 h=1 e=0", ec2, hd2, se2);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (lk !== 1'b0 || bv !== 1'b0 || ec !== 8'd0 || bo !== 3'd0 || du !== 1'b1) begin
            failures++; $display("FAIL async_reset act lk=%b v=%b cnt=%0d b=%0d up=%b exp lk=0 v=0 cnt=0 b=0 up=1", lk, bv, ec, bo, du);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 3'b110);
        checks++; if (lk !== 1'b1 || bo !== 3'd4 || se !== 1'b0 || ec !== 8'd0) begin
            failures++; $display("FAIL relock act lk=%b b=%0d e=%b cnt=%0d exp lk=1 b=4 e=0 cnt=0", lk, bo, se, ec);
        end
    endtask

    task automatic test_clr_priority();
        drive(1'b0, 1'b1, 3'b011);
        checks++; if (se !== 1'b1 || ec !== 8'd1) begin failures++; $display("FAIL pre_clr_jump act e=%b cnt=%0d exp e=1 cnt=1", se, ec); end
        drive(1'b1, 1'b1, 3'b111);
        checks++; if (lk !== 1'b0 || bv !== 1'b0 || se !== 1'b0 || hd !== 1'b0 || ec !== 8'd0) begin
            failures++; $display("FAIL clr_with_valid act lk=%b v=%b e=%b h=%b cnt=%0d exp lk=0 v=0 e=0 h=0 cnt=0", lk, bv, se, hd, ec);
        end
        drive(1'b0, 1'b1, 3'b000);
        checks++; if (lk !== 1'b1 || bo !== 3'd0 || se !== 1'b0 || bv !== 1'b1) begin
            failures++; $display("FAIL clr_relock act lk=%b b=%0d e=%b v=%b exp lk=1 b=0 e=0 v=1", lk, bo, se, bv);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_increment();
        test_decrement();
        test_illegal();
        test_saturation();
        test_reset_midstream();
        test_clr_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
